// File: rtl/uart_rx_ctrl.sv
// UART 8N1 receive controller: synchronises rx, paces the external baud counter,
// assembles LSB-first frames and hands bytes out through a one-entry valid/ready register.
module uart_rx_ctrl #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rx,
   output logic              count_sig,
   input  logic              bps_clk,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   input  logic              rx_ready,
   output logic              frame_err,
   output logic              overrun,
   output logic              busy
);

   localparam int CNT_W = $clog2(DATA_W) + 1;
   localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_DATA  = 3'd2;
   localparam logic [2:0] S_STOP  = 3'd3;
   localparam logic [2:0] S_BREAK = 3'd4;

   logic [2:0]        state;
   logic              rx_meta;
   logic              rx_s;
   logic              rx_d;
   logic              fall;
   logic [CNT_W-1:0]  bit_cnt;
   logic [DATA_W-1:0] shreg;
   logic              stop_tick;
   logic              stop_ok;
   logic              can_load;

   assign fall      = rx_d & ~rx_s;
   assign stop_tick = (state == S_STOP) && bps_clk;
   assign stop_ok   = stop_tick && rx_s;
   // The register can take a new byte when empty or when the old one leaves this cycle.
   assign can_load  = ~rx_valid | rx_ready;

   assign count_sig = (state == S_START) || (state == S_DATA) || (state == S_STOP);
   assign busy      = (state != S_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta   <= 1'b1;
         rx_s      <= 1'b1;
         rx_d      <= 1'b1;
         state     <= S_IDLE;
         bit_cnt   <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         rx_meta   <= rx;
         rx_s      <= rx_meta;
         rx_d      <= rx_s;
         frame_err <= 1'b0;
         overrun   <= 1'b0;

         if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end

         case (state)
            S_IDLE: begin
               if (fall) begin
                  state <= S_START;
               end
            end
            S_START: begin
               if (bps_clk) begin
                  if (!rx_s) begin
                     state   <= S_DATA;
                     bit_cnt <= '0;
                  end else begin
                     state <= S_IDLE;
                  end
               end
            end
            S_DATA: begin
               if (bps_clk) begin
                  bit_cnt <= bit_cnt + CNT_W'(1);
                  if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                     state <= S_STOP;
                  end
               end
            end
            S_STOP: begin
               if (bps_clk) begin
                  if (rx_s) begin
                     state <= S_IDLE;
                     if (can_load) begin
                        rx_data  <= shreg;
                        rx_valid <= 1'b1;
                     end else begin
                        overrun <= 1'b1;
                     end
                  end else begin
                     frame_err <= 1'b1;
                     state     <= S_BREAK;
                  end
               end
            end
            S_BREAK: begin
               // Held-low line: only a return to idle level re-arms start detection.
               if (rx_s) begin
                  state <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Shift register carries data only; a stale value is never delivered.
   always_ff @(posedge clk) begin
      if ((state == S_DATA) && bps_clk) begin
         shreg[bit_cnt[IDX_W-1:0]] <= rx_s;
      end
   end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

UART receive controller that sequences the receive baud-tick generator and assembles serial frames into parallel bytes. It detects the start-bit falling edge, enables the baud counter, and samples each bit on the mid-bit tick. It delivers 8N1 bytes (1 start, DATA_W data LSB first, 1 stop) through a one-entry valid/ready output register. It sits between the synchronised `rx` pad and the receive FIFO/consumer, and owns the `count_sig`/`bps_clk` pair of the rx baud module.

## Interface
- `DATA_W`, default 8: data bits per frame.
- `clk`  in  1  system clock (50 MHz).
- `rst`  in  1  synchronous active-high reset.
- `rx`  in  1  asynchronous serial line, idle high.
- `count_sig`  out  1  baud counter enable. The baud module counts while this is high and holds at 0 while it is low.
- `bps_clk`  in  1  one-cycle mid-bit tick from the baud module.
- `rx_data`  out  DATA_W  received byte, valid while `rx_valid`=1.
- `rx_valid`  out  1  byte available. Held high until `rx_ready`.
- `rx_ready`  in  1  consumer accepts the byte in the same cycle as `rx_valid`=1.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun`  out  1  one-cycle pulse: new byte dropped because the output register was still full.
- `busy`  out  1  high in every state except IDLE.

## Operation
- **Input stage:** 2-flop synchroniser `rx`→`rx_meta`→`rx_s`, plus delay flop `rx_d`. All three reset to 1. `fall` = `rx_d & ~rx_s`.
- **States:** IDLE, START, DATA, STOP, BREAK. `count_sig` = 1 in START/DATA/STOP and 0 in IDLE/BREAK.
- **IDLE:** on `fall`, go to START.
- **START:** on `bps_clk`:
  - `rx_s`=0: go to DATA with `bit_cnt`=0.
  - `rx_s`=1: glitch; go to IDLE with no output and no error.
- **DATA:** on `bps_clk`, `shreg[bit_cnt]`<=`rx_s` (LSB first), `bit_cnt`++. On the tick that samples bit DATA_W-1, go to STOP. `bit_cnt` is $clog2(DATA_W)+1 bits wide and never wraps.
- **STOP:** on `bps_clk`:
  - `rx_s`=1: deliver `shreg` and go to IDLE.
  - `rx_s`=0: pulse `frame_err`, discard `shreg`, and go to BREAK.
- **BREAK:** wait for `rx_s`=1, then go to IDLE. A held-low line therefore never re-triggers a start.
- **Delivery rules (evaluated in the STOP-success cycle):**
  - `rx_valid`=0: `rx_data`<=`shreg`, `rx_valid`<=1.
  - `rx_valid`=1 and `rx_ready`=1: `rx_data`<=`shreg`, `rx_valid` stays 1. The old byte is consumed and the new one is loaded.
  - `rx_valid`=1 and `rx_ready`=0: keep the old byte, drop the new one, pulse `overrun`.
- **Handshake:** `rx_valid`=1 and `rx_ready`=1 with no delivery in the same cycle clears `rx_valid` on the next edge. `rx_data` holds its last value after it is consumed.
- `bps_clk` pulses received in IDLE or BREAK are ignored.
- **Reset:** `rst` sampled high takes effect at the next edge and overrides everything, including reset mid-frame. The partial frame is discarded.

## Timing
- **Reset values:** state IDLE, `count_sig`=0, `rx_data`=0, `rx_valid`=0, `frame_err`=0, `overrun`=0, `busy`=0, sync flops = 1.
- **Start detect:** `rx` low sampled at edge k gives `rx_s`=0 after edge k+1, `fall` during cycle k+1..k+2, and START with `count_sig`=1 after edge k+2.
- **Bit sampling:** the first `bps_clk` arrives mid-start-bit. Each later tick is one bit period (5208 clk at 9600 bd) after the previous one.
- **Output latency:** `rx_valid` rises on the edge after the stop-bit `bps_clk` cycle, which is about 9.5 bit periods after the start edge.
- **Registered outputs:** `frame_err` and `overrun` are registered and high for exactly one cycle.
- **Back-to-back frames:** after returning to IDLE at mid-stop, `count_sig` drops for at least one cycle, so the baud counter restarts at 0 for the next frame. A start edge arriving half a bit after the stop sample is accepted.

## Test plan
The bench pairs the block with the rx baud-tick generator: 5208-clk period, tick at count 2603.
- **Single byte:** frame 0xA5 at 9600 bd, `rx_ready`=1 → one cycle of `rx_valid`=1 with `rx_data`=0xA5, `frame_err`=0, `busy` low after mid-stop.
- **Start glitch:** `rx` low for 1000 clk → return to IDLE after the first tick, `count_sig`=0, no `rx_valid`, no `frame_err`.
- **Framing error:** frame 0x3C with stop bit low, and `rx` held low for 3 further bit times → one `frame_err` pulse, no `rx_valid`, stays in BREAK until `rx` is high, then 0x55 is received correctly.
- **Overrun:** 0x11 then 0x22 back-to-back with `rx_ready`=0 → `rx_data`=0x11 held, one `overrun` pulse at the second stop. Then `rx_ready`=1 for one cycle → `rx_valid` falls.
- **Simultaneous accept:** `rx_ready` asserted exactly in the second frame's STOP-success cycle → `rx_data`=0x22, `rx_valid` stays 1, no `overrun`.
- **Reset mid-frame:** `rst` pulsed during DATA bit 4 → all outputs at reset values next cycle. The following frame 0xFF is received correctly.
